// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU, state and instruction-class definitions for the control sequencer.
package ctrl_pkg;

    localparam int unsigned OPW  = 5;
    localparam int unsigned ALUW = 5;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam logic [ALUW-1:0] ALU_NONE = 5'd0;
    localparam logic [ALUW-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALUW-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALUW-1:0] ALU_AND  = 5'd3;
    localparam logic [ALUW-1:0] ALU_OR   = 5'd4;
    localparam logic [ALUW-1:0] ALU_MUL  = 5'd5;
    localparam logic [ALUW-1:0] ALU_DIV  = 5'd6;

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_ADDI, C_LDI, C_LD, C_ST, C_MULDIV, C_JR, C_NOP, C_HALT, C_ILLEGAL
    } iclass_t;

    typedef struct packed {
        logic pcout;
        logic pcin;
        logic incpc;
        logic marin;
        logic mdrin;
        logic mdrout;
        logic read;
        logic write;
        logic irin;
        logic yin;
        logic zin;
        logic zlowout;
        logic zhighout;
        logic hiin;
        logic loin;
        logic cout;
        logic baout;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
    } strobes_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath control bundle: IR/memory-ready inputs and every datapath strobe.
interface control_sequencer_if;
    import ctrl_pkg::*;

    logic [31:0]     ir;
    logic            mem_ready;
    logic            PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
    logic            Yin, Zin, Zlowout, ZHighout, HIin, LOin, Cout, BAout;
    logic            Gra, Grb, Grc, Rin, Rout;
    logic [ALUW-1:0] alu_op;
    logic            run;
    logic            illegal;

    modport master (
        input  ir, mem_ready,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
        output Yin, Zin, Zlowout, ZHighout, HIin, LOin, Cout, BAout,
        output Gra, Grb, Grc, Rin, Rout, alu_op, run, illegal
    );

    modport slave (
        output ir, mem_ready,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
        input  Yin, Zin, Zlowout, ZHighout, HIin, LOin, Cout, BAout,
        input  Gra, Grb, Grc, Rin, Rout, alu_op, run, illegal
    );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode to instruction-class and ALU-operation mapping.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPW-1:0]  opcode,
    output iclass_t         iclass_c,
    output logic [ALUW-1:0] alu_op_c
);

    always_comb begin
        iclass_c = C_ILLEGAL;
        alu_op_c = ALU_NONE;
        case (opcode)
            OP_ADD:  begin iclass_c = C_ALU;    alu_op_c = ALU_ADD; end
            OP_SUB:  begin iclass_c = C_ALU;    alu_op_c = ALU_SUB; end
            OP_AND:  begin iclass_c = C_ALU;    alu_op_c = ALU_AND; end
            OP_OR:   begin iclass_c = C_ALU;    alu_op_c = ALU_OR;  end
            OP_ADDI: begin iclass_c = C_ADDI;   alu_op_c = ALU_ADD; end
            OP_LDI:  begin iclass_c = C_LDI;    alu_op_c = ALU_ADD; end
            OP_LD:   begin iclass_c = C_LD;     alu_op_c = ALU_ADD; end
            OP_ST:   begin iclass_c = C_ST;     alu_op_c = ALU_ADD; end
            OP_MUL:  begin iclass_c = C_MULDIV; alu_op_c = ALU_MUL; end
            OP_DIV:  begin iclass_c = C_MULDIV; alu_op_c = ALU_DIV; end
            OP_JR:   iclass_c = C_JR;
            OP_NOP:  iclass_c = C_NOP;
            OP_HALT: iclass_c = C_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, per-class execute T3-T7, memory wait states, HALT.
// Optional CTRL_ILLEGAL_TRAP_EN: unknown opcodes set a sticky illegal flag and halt.
module control_sequencer
    import ctrl_pkg::*;
(
    input logic                 clock,
    input logic                 clear,
    control_sequencer_if.master bus
);

    state_t          state;
    logic            illegal_q;
    iclass_t         iclass;
    logic [ALUW-1:0] dec_alu;
    logic [ALUW-1:0] alu;
    strobes_t        s;
    logic            unused_ir;

    assign unused_ir = ^bus.ir[26:0];

    ctrl_decode u_decode (
        .opcode   (bus.ir[31:27]),
        .iclass_c (iclass),
        .alu_op_c (dec_alu)
    );

    // Step sequencing; T1, ld T6 and st T7 hold until mem_ready
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= S_T0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_T0: state <= S_T1;
                S_T1: if (bus.mem_ready) state <= S_T2;
                S_T2: state <= S_T3;
                S_T3: begin
                    case (iclass)
                        C_JR, C_NOP: state <= S_T0;
                        C_HALT:      state <= S_HALT;
                        C_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            state     <= S_HALT;
                            illegal_q <= 1'b1;
`else
                            state     <= S_T0;
`endif
                        end
                        default:     state <= S_T4;
                    endcase
                end
                S_T4: state <= S_T5;
                S_T5: state <= (iclass inside {C_LD, C_ST, C_MULDIV}) ? S_T6 : S_T0;
                S_T6: begin
                    if (iclass == C_MULDIV)
                        state <= S_T0;
                    else if (iclass == C_ST || bus.mem_ready)
                        state <= S_T7;
                end
                S_T7: if (iclass == C_LD || bus.mem_ready) state <= S_T0;
                S_HALT: state <= S_HALT;
                default: state <= S_T0;
            endcase
        end
    end

    // Moore decode of state and opcode; forced quiet while clear is high
    always_comb begin
        s   = '0;
        alu = ALU_NONE;
        if (!clear) begin
            case (state)
                S_T0: begin s.pcout = 1'b1; s.marin = 1'b1; s.incpc = 1'b1; s.zin = 1'b1; end
                S_T1: begin s.zlowout = 1'b1; s.pcin = 1'b1; s.read = 1'b1; s.mdrin = 1'b1; end
                S_T2: begin s.mdrout = 1'b1; s.irin = 1'b1; end
                S_T3: begin
                    case (iclass)
                        C_ALU, C_ADDI:      begin s.grb = 1'b1; s.rout = 1'b1;  s.yin = 1'b1; end
                        C_LDI, C_LD, C_ST:  begin s.grb = 1'b1; s.baout = 1'b1; s.yin = 1'b1; end
                        C_MULDIV:           begin s.gra = 1'b1; s.rout = 1'b1;  s.yin = 1'b1; end
                        C_JR:               begin s.gra = 1'b1; s.rout = 1'b1;  s.pcin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T4: begin
                    s.zin = 1'b1;
                    alu   = dec_alu;
                    case (iclass)
                        C_ALU:    begin s.grc = 1'b1; s.rout = 1'b1; end
                        C_MULDIV: begin s.grb = 1'b1; s.rout = 1'b1; end
                        default:  s.cout = 1'b1;
                    endcase
                end
                S_T5: begin
                    s.zlowout = 1'b1;
                    case (iclass)
                        C_LD, C_ST: s.marin = 1'b1;
                        C_MULDIV:   s.loin  = 1'b1;
                        default:    begin s.gra = 1'b1; s.rin = 1'b1; end
                    endcase
                end
                S_T6: begin
                    case (iclass)
                        C_LD:     begin s.read = 1'b1; s.mdrin = 1'b1; end
                        C_ST:     begin s.gra = 1'b1; s.rout = 1'b1; s.mdrin = 1'b1; end
                        C_MULDIV: begin s.zhighout = 1'b1; s.hiin = 1'b1; end
                        default: ;
                    endcase
                end
                S_T7: begin
                    if (iclass == C_LD) begin
                        s.mdrout = 1'b1; s.gra = 1'b1; s.rin = 1'b1;
                    end else begin
                        s.write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.PCout    = s.pcout;
    assign bus.PCin     = s.pcin;
    assign bus.IncPC    = s.incpc;
    assign bus.MARin    = s.marin;
    assign bus.MDRin    = s.mdrin;
    assign bus.MDRout   = s.mdrout;
    assign bus.Read     = s.read;
    assign bus.Write    = s.write;
    assign bus.IRin     = s.irin;
    assign bus.Yin      = s.yin;
    assign bus.Zin      = s.zin;
    assign bus.Zlowout  = s.zlowout;
    assign bus.ZHighout = s.zhighout;
    assign bus.HIin     = s.hiin;
    assign bus.LOin     = s.loin;
    assign bus.Cout     = s.cout;
    assign bus.BAout    = s.baout;
    assign bus.Gra      = s.gra;
    assign bus.Grb      = s.grb;
    assign bus.Grc      = s.grc;
    assign bus.Rin      = s.rin;
    assign bus.Rout     = s.rout;
    assign bus.alu_op   = alu;
    assign bus.run      = !clear && (state != S_HALT);
    assign bus.illegal  = illegal_q && !clear;

endmodule
